// File: rtl/link_tester_pkg.sv
// Shared types and constants for the link tester.
package link_tester_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BUTTON = 2'd1,
    MODE_CONT   = 2'd2,
    MODE_BURST  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    PAT_FIXED = 2'd0,
    PAT_INCR  = 2'd1,
    PAT_LFSR  = 2'd2,
    PAT_RSVD  = 2'd3
  } pattern_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_WAIT  = 2'd0;
  localparam state_t ST_READY = 2'd1;
  localparam state_t ST_SENT  = 2'd2;

  // Right-shift Galois masks giving maximal-length sequences for widths 4..16.
  function automatic logic [15:0] lfsr_taps(input int unsigned n);
    case (n)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hB400;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/link_tester_exp_fifo.sv
// Expected-value FIFO: holds payloads sent but not yet received.
module exp_fifo #(
  parameter int unsigned N_PKT = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [N_PKT-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [N_PKT-1:0] head
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [N_PKT-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; push+pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/link_tester.sv
// Link tester: sends pattern packets to an encoder and checks decoder loopback.
module link_tester
  import link_tester_pkg::*;
#(
  parameter int unsigned N_PKT      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RATE_LIMIT = 500_000,
  parameter int unsigned TIMEOUT    = 2_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [1:0]       pattern,
  input  logic             send_n,
  input  logic [N_PKT-1:0] sw_data,
  input  logic [7:0]       burst_len,
  input  logic             tx_avail,
  output logic             tx_start,
  output logic [N_PKT-1:0] tx_data,
  input  logic             rx_avail,
  input  logic [N_PKT-1:0] rx_data,
  input  logic             rx_error,
  output logic [CNT_W-1:0] sent_ct,
  output logic [CNT_W-1:0] ok_ct,
  output logic [CNT_W-1:0] err_ct,
  output logic [CNT_W-1:0] bad_ct,
  output logic             done
);

  localparam int unsigned GAP_W = (RATE_LIMIT < 1) ? 1 : $clog2(RATE_LIMIT + 1);
  localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(RATE_LIMIT);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [N_PKT-1:0] TAPS    = N_PKT'(lfsr_taps(N_PKT));

  state_t           state;
  state_t           state_nx;
  logic             can_fire;
  logic             fire;
  logic             load;
  logic             sent_low;
  logic             send_q;
  logic [N_PKT-1:0] incr;
  logic [N_PKT-1:0] lfsr;
  logic [N_PKT-1:0] lfsr_nx;
  logic [N_PKT-1:0] pat_val;
  logic [7:0]       burst_left;
  logic [GAP_W-1:0] gap;
  logic [TMR_W-1:0] timer;
  logic             full;
  logic             empty;
  logic [N_PKT-1:0] head;
  logic             rx_match;
  logic             to_hit;
  logic             pop;
  logic             ok_inc;
  logic             bad_inc;

  // Sender next-state and fire decision; clr forces WAIT and blocks firing.
  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    can_fire = 1'b0;
    case (mode)
      MODE_BUTTON: can_fire = !send_n;
      MODE_CONT:   can_fire = (gap >= GAP_MAX);
      MODE_BURST:  can_fire = (burst_left != 8'd0) && (gap >= GAP_MAX);
      default:     can_fire = 1'b0;
    endcase
    case (state)
      ST_WAIT:  if (mode != MODE_OFF && tx_avail) state_nx = ST_READY;
      ST_READY: begin
        if (mode == MODE_OFF) begin
          state_nx = ST_WAIT;
        end else if (can_fire && !full) begin
          fire     = 1'b1;
          state_nx = ST_SENT;
        end
      end
      ST_SENT:  if ((sent_low || !tx_avail) && (mode != MODE_BUTTON || send_n))
                  state_nx = ST_WAIT;
      default:  state_nx = ST_WAIT;
    endcase
    if (clr) begin
      state_nx = ST_WAIT;
      fire     = 1'b0;
    end
  end

  assign load    = (state == ST_WAIT) && (state_nx == ST_READY);
  assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  // Payload source selection; the reserved code behaves as FIXED.
  always_comb begin
    pat_val = sw_data;
    case (pattern)
      PAT_INCR: pat_val = incr;
      PAT_LFSR: pat_val = lfsr;
      default:  pat_val = sw_data;
    endcase
  end

  // Sender state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_WAIT;
    else        state <= state_nx;
  end

  // Remembers that the encoder went busy during SENT, so a held button can't stall exit.
  always_ff @(posedge clk) begin
    if (!rst_n || clr)         sent_low <= 1'b0;
    else if (state != ST_SENT) sent_low <= 1'b0;
    else if (!tx_avail)        sent_low <= 1'b1;
  end

  // Transmit datapath: start pulse, payload, pattern generators, gap and burst tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_start   <= 1'b0;
      tx_data    <= '0;
      incr       <= '0;
      lfsr       <= N_PKT'(1);
      gap        <= '0;
      burst_left <= 8'd0;
      send_q     <= 1'b1;
    end else if (clr) begin
      tx_start   <= 1'b0;
      incr       <= '0;
      lfsr       <= N_PKT'(1);
      gap        <= '0;
      burst_left <= 8'd0;
      send_q     <= send_n;
    end else begin
      tx_start <= fire;
      send_q   <= send_n;
      if (load) tx_data <= pat_val;
      if (fire) begin
        incr <= incr + N_PKT'(1);
        lfsr <= lfsr_nx;
        gap  <= '0;
      end else if (gap < GAP_MAX) begin
        gap <= gap + GAP_W'(1);
      end
      if (mode == MODE_BURST && fire)
        burst_left <= burst_left - 8'd1;
      else if (mode == MODE_BURST && send_q && !send_n && burst_left == 8'd0)
        burst_left <= burst_len;
    end
  end

  assign rx_match = (rx_data == head);
  assign to_hit   = !empty && !rx_avail && !rx_error && (timer == TMR_MAX);
  assign pop      = !empty && (rx_avail || rx_error || to_hit);
  assign ok_inc   = rx_avail && !empty && rx_match;
  assign bad_inc  = (rx_avail && (empty || !rx_match)) || to_hit;

  exp_fifo #(
    .N_PKT (N_PKT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (fire),
    .din   (tx_data),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Receive timeout: runs while packets are outstanding, restarts on any receive event.
  always_ff @(posedge clk) begin
    if (!rst_n || clr)                              timer <= '0;
    else if (empty || rx_avail || rx_error || to_hit) timer <= '0;
    else                                            timer <= timer + TMR_W'(1);
  end

  // Saturating statistics and burst completion flag.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sent_ct <= '0;
      ok_ct   <= '0;
      err_ct  <= '0;
      bad_ct  <= '0;
      done    <= 1'b1;
    end else begin
      if (fire     && !(&sent_ct)) sent_ct <= sent_ct + CNT_W'(1);
      if (ok_inc   && !(&ok_ct))   ok_ct   <= ok_ct + CNT_W'(1);
      if (rx_error && !(&err_ct))  err_ct  <= err_ct + CNT_W'(1);
      if (bad_inc  && !(&bad_ct))  bad_ct  <= bad_ct + CNT_W'(1);
      done <= (burst_left == 8'd0) && empty;
    end
  end

endmodule
